// File: rtl/arm_regfile_sb.sv
// rtl/arm_regfile_sb.sv - ID-stage register file with two write-back ports and a busy-bit scoreboard
module arm_regfile_sb #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic              wb_collision
);

  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wb_collision_q, wb_collision_d;

  logic                wb0_ok, wb1_ok, issue_ok;
  logic [NUM_REGS-1:0] wb0_hit, wb1_hit, issue_hit;

  // Out-of-range addresses and activity during reset are dropped here once.
  assign wb0_ok   = !rst && wb0_en   && ({1'b0, wb0_addr}   < NREGS);
  assign wb1_ok   = !rst && wb1_en   && ({1'b0, wb1_addr}   < NREGS);
  assign issue_ok = !rst && issue_en && ({1'b0, issue_addr} < NREGS);

  always_comb begin
    wb0_hit   = '0;
    wb1_hit   = '0;
    issue_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wb0_hit[i]   = wb0_ok   && (wb0_addr   == ADDR_W'(i));
      wb1_hit[i]   = wb1_ok   && (wb1_addr   == ADDR_W'(i));
      issue_hit[i] = issue_ok && (issue_addr == ADDR_W'(i));
    end
  end

  // A fresh issue beats a retiring write-back; flush beats everything.
  always_comb begin
    busy_d = busy_q & ~(wb0_hit | wb1_hit);
    busy_d = busy_d | issue_hit;
    if (flush) busy_d = '0;
    wb_collision_d = wb0_ok && wb1_ok && (wb0_addr == wb1_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      busy_q         <= '0;
      wb_collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb1_hit[i])      regs_q[i] <= wb1_data;
        else if (wb0_hit[i]) regs_q[i] <= wb0_data;
      end
      busy_q         <= busy_d;
      wb_collision_q <= wb_collision_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];
  logic [2:0]        rd_busy;

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;
  assign rd_addr[2] = rd_addr3;

  // Port 1 is checked last so it wins a double bypass, matching write priority.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_data[k] = '0;
      rd_busy[k] = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr[k] == ADDR_W'(i)) begin
          rd_data[k] = regs_q[i];
          rd_busy[k] = busy_q[i];
        end
      end
      if (BYPASS != 0) begin
        if (wb0_ok && (wb0_addr == rd_addr[k])) begin
          rd_data[k] = wb0_data;
          rd_busy[k] = 1'b0;
        end
        if (wb1_ok && (wb1_addr == rd_addr[k])) begin
          rd_data[k] = wb1_data;
          rd_busy[k] = 1'b0;
        end
      end
    end
  end

  assign rd_data1     = rd_data[0];
  assign rd_data2     = rd_data[1];
  assign rd_data3     = rd_data[2];
  assign busy1        = rd_busy[0];
  assign busy2        = rd_busy[1];
  assign busy3        = rd_busy[2];
  assign wb_collision = wb_collision_q;

endmodule

// File: tb/tb_arm_regfile_sb.sv
// tb/tb_arm_regfile_sb.sv - directed bench for arm_regfile_sb, bypassing and non-bypassing instances side by side
module tb_arm_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr1, rd_addr2, rd_addr3;
  logic          wb0_en, wb1_en, issue_en, flush;
  logic [AW-1:0] wb0_addr, wb1_addr, issue_addr;
  logic [DW-1:0] wb0_data, wb1_data;

  logic [DW-1:0] a_rd1, a_rd2, a_rd3, b_rd1, b_rd2, b_rd3;
  logic          a_b1, a_b2, a_b3, b_b1, b_b2, b_b3, a_col, b_col;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arm_regfile_sb #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .RESET_VAL('0), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data1(a_rd1), .rd_data2(a_rd2), .rd_data3(a_rd3),
    .busy1(a_b1), .busy2(a_b2), .busy3(a_b3),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .wb_collision(a_col)
  );

  arm_regfile_sb #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .RESET_VAL('0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_data3(b_rd3),
    .busy1(b_b1), .busy2(b_b2), .busy3(b_b3),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .wb_collision(b_col)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb0_en = 1'b0; wb1_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wb0_addr = '0; wb1_addr = '0; issue_addr = '0;
    wb0_data = '0; wb1_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; rd_addr3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: populate state, then async reset mid-cycle
    @(negedge clk);
    wb0_en = 1'b1; wb0_addr = 5'd3; wb0_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_addr = 5'd5;
    @(negedge clk);
    idle();
    rd_addr1 = 5'd3; rd_addr2 = 5'd5; rd_addr3 = 5'd3;
    #1;
    chk("pre_rst_r3", a_rd1, 32'hDEADBEEF);
    chk("pre_rst_busy5", {31'd0, a_b2}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd1_a", a_rd1, 32'h0);
    chk("rst_rd3_b", b_rd3, 32'h0);
    chk("rst_busy", {29'd0, a_b1, a_b2, a_b3}, 32'h0);
    chk("rst_col", {31'd0, a_col}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // 2: write R2 and read it in the same cycle
    @(negedge clk);
    wb0_en = 1'b1; wb0_addr = 5'd2; wb0_data = 32'h11; rd_addr1 = 5'd2;
    #1;
    chk("byp_rd1_a", a_rd1, 32'h11);
    chk("nobyp_rd1_b_old", b_rd1, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("nobyp_rd1_b_new", b_rd1, 32'h11);
    chk("r2_a", a_rd1, 32'h11);

    // 3: same-address collision, port 1 wins
    @(negedge clk);
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'hAAAA;
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h5555;
    rd_addr1 = 5'd7;
    #1;
    chk("byp_prio", a_rd1, 32'h5555);
    after_edge();
    chk("col_set", {31'd0, a_col}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("r7_b", b_rd1, 32'h5555);
    after_edge();
    chk("col_clear", {31'd0, a_col}, 32'd0);

    // 4: scoreboard on R4
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd4; rd_addr2 = 5'd4;
    after_edge();
    chk("issue_r4_a", {31'd0, a_b2}, 32'd1);
    chk("issue_r4_b", {31'd0, b_b2}, 32'd1);
    @(negedge clk);
    idle();
    wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h44;
    #1;
    chk("wb_byp_busy_a", {31'd0, a_b2}, 32'd0);
    chk("wb_nobyp_busy_b", {31'd0, b_b2}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("wb_clear_b", {31'd0, b_b2}, 32'd0);
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd4;
    wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h44;
    @(negedge clk);
    idle();
    #1;
    chk("issue_wins_a", {31'd0, a_b2}, 32'd1);
    chk("issue_wins_b", {31'd0, b_b2}, 32'd1);

    // 5: several pending producers, then flush with a simultaneous issue
    rd_addr1 = 5'd1; rd_addr2 = 5'd6; rd_addr3 = 5'd9;
    @(negedge clk) begin issue_en = 1'b1; issue_addr = 5'd1; end
    @(negedge clk) issue_addr = 5'd6;
    @(negedge clk) issue_addr = 5'd9;
    @(negedge clk);
    idle();
    #1;
    chk("pending_169", {29'd0, a_b1, a_b2, a_b3}, 32'h7);
    @(negedge clk);
    flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd10;
    @(negedge clk);
    idle();
    #1;
    chk("flush_169", {29'd0, a_b1, a_b2, a_b3}, 32'h0);
    rd_addr1 = 5'd10; rd_addr2 = 5'd4;
    #1;
    chk("flush_10_4", {30'd0, a_b1, a_b2}, 32'h0);

    // 6: addresses beyond NUM_REGS must not alias onto R4
    @(negedge clk);
    wb0_en = 1'b1; wb0_addr = 5'd20; wb0_data = 32'hFFFF;
    wb1_en = 1'b1; wb1_addr = 5'd20; wb1_data = 32'hEEEE;
    issue_en = 1'b1; issue_addr = 5'd20;
    rd_addr1 = 5'd20; rd_addr2 = 5'd4;
    #1;
    chk("oor_rd_a", a_rd1, 32'h0);
    chk("oor_busy_a", {31'd0, a_b1}, 32'd0);
    after_edge();
    chk("oor_no_col", {31'd0, a_col}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("oor_r4_data", b_rd2, 32'h44);
    chk("oor_r4_busy", {31'd0, a_b2}, 32'd0);
    chk("oor_rd_b", b_rd1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
